// File: rtl/piso_shift_reg_pkg.sv
// Shared lab5 definitions for the PISO shift register: state encodings and delay constants.
`timescale 100ps/100ps
package piso_shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Delay figures in timescale units (100 ps): flop clk-to-Q and worst-case mux path to D.
    localparam int CLK2Q_DLY   = 10;
    localparam int MUX_DLY_MAX = 105;
    localparam int CLK_PER_MIN = 200;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg_mux2_1.sv
// MUX2_1 cell: selects the parallel-load bit (B) over the shift neighbour (A) when SEL is high.
`timescale 100ps/100ps
module piso_shift_reg_mux2_1 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with BUSY/DONE status.
// Build option LSB_FIRST_EN: serialize from bit 0 upward instead of MSB first.
`timescale 100ps/100ps
module piso_shift_reg
    import piso_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             START,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_d;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_reg_en;
    logic             w_load;

    assign w_load = (r_state == IDLE) && START;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_reg_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                    w_reg_en    = 1'b1;
                end
            end
            SHIFT: begin
                // The final edge still shifts so the tap drains to 0.
                w_reg_en = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_nbr;
`ifdef LSB_FIRST_EN
        if (i == WIDTH - 1) begin : g_end
            assign w_nbr = 1'b0;
        end else begin : g_mid
            assign w_nbr = r_shift[i+1];
        end
`else
        if (i == 0) begin : g_end
            assign w_nbr = 1'b0;
        end else begin : g_mid
            assign w_nbr = r_shift[i-1];
        end
`endif
        piso_shift_reg_mux2_1 u_mux (
            .i_a   (w_nbr),
            .i_b   (DIN[i]),
            .i_sel (w_load),
            .o_y   (w_d[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            if (w_reg_en) begin
                r_shift <= w_d;
            end
        end
    end

`ifdef LSB_FIRST_EN
    assign SOUT = r_shift[0];
`else
    assign SOUT = r_shift[WIDTH-1];
`endif
    assign BUSY = (r_state == SHIFT);
    assign DONE = r_done;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: directed scenarios plus random START traffic
// compared against a per-edge schedule of expected outputs.
`timescale 100ps/100ps
module tb_piso_shift_reg;

    localparam int W = 8;
    localparam int N = 2048;

    logic         CLK   = 1'b0;
    logic         RST_N = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] DIN   = '0;
    logic         SOUT;
    logic         BUSY;
    logic         DONE;

    piso_shift_reg #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .DIN   (DIN),
        .START (START),
        .SOUT  (SOUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #100 CLK = ~CLK;

    // Expected outputs indexed by the number of the edge they follow.
    bit exp_sout [N];
    bit exp_busy [N];
    bit exp_done [N];
    int cyc       = 0;
    int next_free = 0;
    int n_tests   = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_now();
        check("sout", SOUT, exp_sout[cyc]);
        check("busy", BUSY, exp_busy[cyc]);
        check("done", DONE, exp_done[cyc]);
    endtask

    // A transfer accepted at edge e presents its bits on e..e+W-1, pulses DONE after e+W.
    task automatic schedule(input int e, input logic [W-1:0] d);
        for (int k = 0; k < W; k++) begin
            if (e + k < N) begin
`ifdef LSB_FIRST_EN
                exp_sout[e+k] = d[k];
`else
                exp_sout[e+k] = d[W-1-k];
`endif
                exp_busy[e+k] = 1'b1;
            end
        end
        if (e + W < N) exp_done[e+W] = 1'b1;
        next_free = e + W + 1;
    endtask

    task automatic clear_from(input int e);
        for (int j = e; j < N; j++) begin
            exp_sout[j] = 1'b0;
            exp_busy[j] = 1'b0;
            exp_done[j] = 1'b0;
        end
        next_free = 0;
    endtask

    task automatic step(input logic st, input logic [W-1:0] d);
        START = st;
        DIN   = d;
        @(posedge CLK);
        cyc++;
        if (st && RST_N && cyc >= next_free) schedule(cyc, d);
        @(negedge CLK);
        check_now();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom);
    endtask

    initial begin
        // Reset held with START and all-ones data: nothing may load.
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);

        // Basic transfer.
        step(1'b1, 8'hA5);
        idle(W + 2);

        // START during SHIFT is ignored.
        step(1'b1, 8'hF0);
        idle(2);
        step(1'b1, 8'h0F);
        idle(W);

        // Back-to-back: second START lands in the DONE cycle.
        step(1'b1, 8'h81);
        idle(W - 1);
        step(1'b0, 8'h00);
        check("done_cycle", DONE, 1'b1);
        step(1'b1, 8'h7E);
        check("b2b_busy", BUSY, 1'b1);
        idle(W + 1);

        // Asynchronous reset in the middle of a transfer.
        step(1'b1, 8'hC3);
        idle(3);
        START = 1'b0;
        @(posedge CLK);
        cyc++;
        #5;
        check_now();
        #5;
        RST_N = 1'b0;
        clear_from(cyc);
        #10;
        check("rst_async_sout", SOUT, 1'b0);
        check("rst_async_busy", BUSY, 1'b0);
        check("rst_async_done", DONE, 1'b0);
        #50;
        RST_N = 1'b1;
        @(negedge CLK);
        check_now();
        idle(W + 2);
        step(1'b1, 8'h01);
        idle(W + 2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) == 0), $urandom);
        end
        idle(W + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
